// File: rtl/mc_core_pkg.sv
// Shared encodings for mc_branch_core: ALU opcodes, write-back selects,
// FSM states and the instruction word layout.
package mc_core_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_LT  = 4'd8;
  localparam logic [3:0] ALU_LTU = 4'd9;
  localparam logic [3:0] ALU_EQ  = 4'd10;
  localparam logic [3:0] ALU_NE  = 4'd11;
  localparam logic [3:0] ALU_GE  = 4'd12;
  localparam logic [3:0] ALU_GEU = 4'd13;

  localparam logic [1:0] WS_IMM  = 2'd0;
  localparam logic [1:0] WS_IN   = 2'd1;
  localparam logic [1:0] WS_ALU  = 2'd2;
  localparam logic [1:0] WS_ZERO = 2'd3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  // Field order from bit 31 down to bit 0.
  typedef struct packed {
    logic       b;
    logic       c;
    logic       halt;
    logic [1:0] ws;
    logic [3:0] op;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [4:0] wa;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero, synchronous active-low clear.
module mc_regfile
  import mc_core_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int IDX_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  ra1,
  input  logic [IDX_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_r [NREG];

  // Storage update: clear on reset, otherwise write any register but 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs_r[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs_r[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_r[ra2];

endmodule

// File: rtl/mc_branch_core.sv
// Multi-cycle branch/ALU core: fetches over req/ack, executes one instruction
// per FETCH/EXEC pair, writes back or branches, and halts on request.
module mc_branch_core
  import mc_core_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NREG     = 32,
  parameter int IN_W     = 10,
  parameter int OUT_REG  = 31,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  input  logic [IN_W-1:0]   in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [CNT_W-1:0]  retired_o,
  output logic              halted_o
);

  localparam int IDX_W = $clog2(NREG);
  localparam int SH_W  = $clog2(DATA_W);

  state_e            state_r;
  logic              req_r;
  logic [ADDR_W-1:0] pc_r;
  instr_t            instr_r;
  logic              in_ready_r;
  logic [CNT_W-1:0]  retired_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              halted_r;

  logic [DATA_W-1:0] rd1_s, rd2_s, alu_s, wd_s;
  logic              flag_s, wb_en_s, commit_s, we_s, out_hit_s;
  logic [ADDR_W-1:0] next_pc_s, br_off_s;
  logic [SH_W-1:0]   shamt_s;
  logic [IDX_W-1:0]  wa_s;
  instr_t            fetched_s;

  assign fetched_s = instr_t'(imem_data_i);
  assign wa_s      = instr_r.wa[IDX_W-1:0];
  assign shamt_s   = rd2_s[SH_W-1:0];
  assign wb_en_s   = !instr_r.b && !instr_r.c && !instr_r.halt;
  // An input-port instruction waits in EXEC until its handshake completes.
  assign commit_s  = (state_r == S_EXEC) && (!in_ready_r || in_valid_i);
  assign we_s      = commit_s && wb_en_s;
  assign out_hit_s = (wa_s == IDX_W'(OUT_REG));
  assign br_off_s  = ADDR_W'($signed({instr_r.imm, 2'b00}));

  mc_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (clk_i),
    .rst_n (rst_i),
    .ra1   (instr_r.ra1[IDX_W-1:0]),
    .ra2   (instr_r.ra2[IDX_W-1:0]),
    .rd1   (rd1_s),
    .rd2   (rd2_s),
    .we    (we_s),
    .wa    (wa_s),
    .wd    (wd_s)
  );

  // ALU result and compare flag; the flag stays low for non-compare ops.
  always_comb begin
    alu_s  = '0;
    flag_s = 1'b0;
    case (instr_r.op)
      ALU_ADD: alu_s = rd1_s + rd2_s;
      ALU_SUB: alu_s = rd1_s - rd2_s;
      ALU_XOR: alu_s = rd1_s ^ rd2_s;
      ALU_OR:  alu_s = rd1_s | rd2_s;
      ALU_AND: alu_s = rd1_s & rd2_s;
      ALU_SLL: alu_s = rd1_s << shamt_s;
      ALU_SRL: alu_s = rd1_s >> shamt_s;
      ALU_SRA: alu_s = $signed(rd1_s) >>> shamt_s;
      ALU_LT:  flag_s = $signed(rd1_s) < $signed(rd2_s);
      ALU_LTU: flag_s = rd1_s < rd2_s;
      ALU_EQ:  flag_s = rd1_s == rd2_s;
      ALU_NE:  flag_s = rd1_s != rd2_s;
      ALU_GE:  flag_s = $signed(rd1_s) >= $signed(rd2_s);
      ALU_GEU: flag_s = rd1_s >= rd2_s;
      default: alu_s = '0;
    endcase
    if (flag_s) begin
      alu_s = DATA_W'(1'b1);
    end else begin
      alu_s = alu_s;
    end
  end

  // Write-back data select.
  always_comb begin
    wd_s = '0;
    case (instr_r.ws)
      WS_IMM:  wd_s = DATA_W'($signed(instr_r.imm));
      WS_IN:   wd_s = DATA_W'($signed(in_data_i));
      WS_ALU:  wd_s = alu_s;
      WS_ZERO: wd_s = '0;
      default: wd_s = '0;
    endcase
  end

  // Next PC in priority order: HALT, jump, taken branch, sequential.
  always_comb begin
    next_pc_s = pc_r;
    if (instr_r.halt) begin
      next_pc_s = pc_r;
    end else if (instr_r.b || (instr_r.c && flag_s)) begin
      next_pc_s = pc_r + br_off_s;
    end else begin
      next_pc_s = pc_r + ADDR_W'(32'd4);
    end
  end

  // Control FSM with all registered outputs. The request is raised one cycle
  // after reset so that a fetch in flight at reset is visibly dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= S_FETCH;
      req_r       <= 1'b0;
      pc_r        <= ADDR_W'(RESET_PC);
      instr_r     <= '0;
      in_ready_r  <= 1'b0;
      retired_r   <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (!req_r) begin
            req_r <= 1'b1;
          end else if (imem_ack_i) begin
            instr_r    <= fetched_s;
            req_r      <= 1'b0;
            state_r    <= S_EXEC;
            in_ready_r <= !fetched_s.b && !fetched_s.c && !fetched_s.halt &&
                          (fetched_s.ws == WS_IN);
          end
        end
        S_EXEC: begin
          if (commit_s) begin
            pc_r       <= next_pc_s;
            retired_r  <= retired_r + CNT_W'(1'b1);
            in_ready_r <= 1'b0;
            if (we_s && out_hit_s) begin
              out_data_r  <= wd_s;
              out_valid_r <= 1'b1;
            end
            if (instr_r.halt) begin
              state_r  <= S_HALT;
              halted_r <= 1'b1;
            end else begin
              state_r <= S_FETCH;
              req_r   <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state_r <= S_HALT;
        end
        default: begin
          state_r <= S_FETCH;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = pc_r;
  assign in_ready_o  = in_ready_r;
  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign pc_o        = pc_r;
  assign retired_o   = retired_r;
  assign halted_o    = halted_r;

endmodule

// File: tb/tb_mc_branch_core.sv
// Scoreboard bench for mc_branch_core: directed programs push expected commit
// records; a monitor pops and compares on every retired-count step.
module tb_mc_branch_core;
  import mc_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;

  always #5 clk = ~clk;

  mc_branch_core #(
    .DATA_W(32), .ADDR_W(32), .NREG(32), .IN_W(10),
    .OUT_REG(31), .RESET_PC(0), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid),
    .pc_o(pc), .retired_o(retired), .halted_o(halted)
  );

  // Instruction memory model with a programmable number of wait cycles.
  logic [31:0] mem [0:63];
  int          mem_wait = 0;
  logic        ack_force = 1'b0;
  int          wait_cnt = 0;

  assign imem_ack  = ack_force | (imem_req && (wait_cnt == mem_wait));
  assign imem_data = mem[imem_addr[7:2]];

  int cyc = 0;
  int hs_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready && in_valid) hs_cnt <= hs_cnt + 1;
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic        ov;
    logic [31:0] od;
    logic        hl;
    int          dcyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          last_cyc = 0;
  logic [31:0] prev_ret = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic void push(input logic [31:0] p, input logic [31:0] r, input logic ov,
                               input logic [31:0] od, input logic hl, input int d);
    exp_t e;
    e.pc = p; e.ret = r; e.ov = ov; e.od = od; e.hl = hl; e.dcyc = d;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] enc(input logic b, input logic c, input logic h,
                                      input logic [1:0] ws, input logic [3:0] op,
                                      input logic [4:0] ra1, input logic [4:0] ra2,
                                      input logic [4:0] wa, input logic [7:0] imm);
    return {b, c, h, ws, op, ra1, ra2, wa, imm};
  endfunction

  // Monitor: a change of retired_o marks a commit; compare against the queue head.
  always @(negedge clk) begin
    if (rst_i !== 1'b1) begin
      prev_ret = retired;
    end else if (retired != prev_ret) begin
      prev_ret = retired;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_commit: got retired %0d expected no commit", retired);
      end else begin
        mon_e = sb.pop_front();
        chk("pc", pc, mon_e.pc);
        chk("retired", retired, mon_e.ret);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mon_e.ov});
        chk("out_data", out_data, mon_e.od);
        chk("halted", {31'd0, halted}, {31'd0, mon_e.hl});
        if (mon_e.dcyc > 0) chk("commit_cycles", cyc - last_cyc, mon_e.dcyc);
      end
      last_cyc = cyc;
    end else if (out_valid) begin
      n_vec++; n_err++;
      $display("FAIL spurious_out_valid: got 1 expected 0 at pc %h", pc);
    end
  end

  task automatic reset_hold();
    rst_i = 1'b0; in_valid = 1'b0; in_data = '0; ack_force = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'h0);
  endtask

  task automatic release_reset();
    rst_i = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_left", sb.size(), 32'h0);
  endtask

  task automatic halt_check(input logic [31:0] p, input logic [31:0] r);
    int req_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (imem_req) req_seen++;
    end
    chk("halt_req_count", req_seen, 32'h0);
    chk("halt_pc", pc, p);
    chk("halt_retired", retired, r);
    chk("halt_flag", {31'd0, halted}, 32'h1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  initial begin
    int hs0;
    rst_i = 1'b0; in_valid = 1'b0; in_data = '0;

    // Program 1: zero-wait memory, immediates, ALU, x0, OUT_REG, HALT.
    clear_mem();
    mem_wait = 0;
    mem[0] = enc(1'b0, 1'b0, 1'b0, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'hFF);
    mem[1] = enc(1'b0, 1'b0, 1'b0, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd1, 8'd5);
    mem[2] = enc(1'b0, 1'b0, 1'b0, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd2, 8'd3);
    mem[3] = enc(1'b0, 1'b0, 1'b0, WS_ALU, ALU_SUB, 5'd1, 5'd2, 5'd31, 8'd0);
    mem[4] = enc(1'b0, 1'b0, 1'b0, WS_ALU, ALU_SUB, 5'd1, 5'd2, 5'd0, 8'd0);
    mem[5] = enc(1'b0, 1'b0, 1'b0, WS_ALU, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd0);
    mem[6] = enc(1'b0, 1'b0, 1'b0, WS_ALU, ALU_SLL, 5'd1, 5'd2, 5'd31, 8'd0);
    mem[7] = enc(1'b0, 1'b0, 1'b0, WS_ALU, ALU_ADD, 5'd31, 5'd2, 5'd31, 8'd0);
    mem[8] = enc(1'b0, 1'b0, 1'b1, WS_ALU, ALU_ADD, 5'd1, 5'd1, 5'd31, 8'd0);
    push(32'h04, 32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 0);
    push(32'h08, 32'd2, 1'b0, 32'hFFFFFFFF, 1'b0, 2);
    push(32'h0C, 32'd3, 1'b0, 32'hFFFFFFFF, 1'b0, 2);
    push(32'h10, 32'd4, 1'b1, 32'h00000002, 1'b0, 2);
    push(32'h14, 32'd5, 1'b0, 32'h00000002, 1'b0, 2);
    push(32'h18, 32'd6, 1'b1, 32'h00000000, 1'b0, 2);
    push(32'h1C, 32'd7, 1'b1, 32'h00000028, 1'b0, 2);
    push(32'h20, 32'd8, 1'b1, 32'h0000002B, 1'b0, 2);
    push(32'h20, 32'd9, 1'b0, 32'h0000002B, 1'b1, 2);
    reset_hold();
    release_reset();
    drain();
    halt_check(32'h20, 32'd9);

    // Program 2: jump, taken and not-taken signed compare branch.
    clear_mem();
    mem[0] = enc(1'b0, 1'b0, 1'b0, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd2, 8'd1);
    mem[1] = enc(1'b0, 1'b0, 1'b0, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd1, 8'hFF);
    mem[2] = enc(1'b1, 1'b0, 1'b0, WS_IN,  ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd2);
    mem[3] = enc(1'b0, 1'b0, 1'b0, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd1, 8'd2);
    mem[4] = enc(1'b0, 1'b1, 1'b0, WS_ALU, ALU_LT,  5'd1, 5'd2, 5'd31, 8'hFF);
    mem[5] = enc(1'b0, 1'b0, 1'b0, WS_ALU, ALU_ADD, 5'd1, 5'd2, 5'd31, 8'd0);
    mem[6] = enc(1'b0, 1'b0, 1'b1, WS_IMM, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd7);
    push(32'h04, 32'd1, 1'b0, 32'h0, 1'b0, 0);
    push(32'h08, 32'd2, 1'b0, 32'h0, 1'b0, 2);
    push(32'h10, 32'd3, 1'b0, 32'h0, 1'b0, 2);
    push(32'h0C, 32'd4, 1'b0, 32'h0, 1'b0, 2);
    push(32'h10, 32'd5, 1'b0, 32'h0, 1'b0, 2);
    push(32'h14, 32'd6, 1'b0, 32'h0, 1'b0, 2);
    push(32'h18, 32'd7, 1'b1, 32'h3, 1'b0, 2);
    push(32'h18, 32'd8, 1'b0, 32'h3, 1'b1, 2);
    reset_hold();
    release_reset();
    drain();
    halt_check(32'h18, 32'd8);

    // Program 3: reset mid-fetch, late ack, input-port stall, wait-state memory.
    clear_mem();
    mem[0] = enc(1'b0, 1'b0, 1'b0, WS_IN, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd0);
    mem[1] = enc(1'b1, 1'b0, 1'b0, WS_IN, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd1);
    mem[2] = enc(1'b0, 1'b0, 1'b0, WS_IN, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd0);
    mem[3] = enc(1'b0, 1'b0, 1'b1, WS_IN, ALU_ADD, 5'd0, 5'd0, 5'd31, 8'd0);
    push(32'h04, 32'd1, 1'b1, 32'hFFFFFE00, 1'b0, 0);
    push(32'h08, 32'd2, 1'b0, 32'hFFFFFE00, 1'b0, 4);
    push(32'h0C, 32'd3, 1'b1, 32'h000001FF, 1'b0, 4);
    push(32'h0C, 32'd4, 1'b0, 32'h000001FF, 1'b1, 4);
    mem_wait = 4;
    reset_hold();
    release_reset();
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("req_dropped_after_reset", {31'd0, imem_req}, 32'h0);
    rst_i = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    chk("late_ack_ignored_req", {31'd0, imem_req}, 32'h1);
    chk("refetch_addr", imem_addr, 32'h0);
    mem_wait = 2;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    chk("in_ready_rise", {31'd0, in_ready}, 32'h1);
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_ready_stall", {31'd0, in_ready}, 32'h1);
    end
    chk("no_commit_during_stall", retired, 32'h0);
    in_valid = 1'b1;
    in_data  = 10'h200;
    @(negedge clk);
    chk("in_ready_clear", {31'd0, in_ready}, 32'h0);
    in_data  = 10'h1FF;
    drain();
    chk("handshake_count", hs_cnt - hs0, 32'd2);
    in_valid = 1'b0;
    halt_check(32'h0C, 32'd4);

    reset_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_branch_core.md
# mc_branch_core

Parametrised multi-cycle successor to the single-cycle branch/ALU datapath. It fetches 32-bit instructions over a req/ack handshake from an external instruction memory and executes them against an internal register file. Each instruction computes an ALU result, sign-extends an immediate, or takes a switch input, then either branches or writes back. New over the previous generation: variable-latency fetch, valid/ready input port, latched output register port, HALT, retired-instruction counter.

## Interface
- DATA_W, 32, datapath/register width (8..32)
- ADDR_W, 32, PC / instruction address width
- NREG, 32, register count, power of 2, 2..32; register index = low log2(NREG) bits of 5-bit field
- IN_W, 10, input-port width (≤ DATA_W)
- OUT_REG, 31, register index mirrored to output port (nonzero, < NREG)
- RESET_PC, 0, PC after reset (multiple of 4)
- CNT_W, 32, retired counter width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, synchronous, active-low
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  fetch address (= PC)
- imem_ack_i  in  1  fetch data valid
- imem_data_i  in  32  instruction word
- in_data_i  in  IN_W  input-port data
- in_valid_i  in  1  input data valid
- in_ready_o  out  1  core consuming input
- out_data_o  out  DATA_W  last value written to OUT_REG
- out_valid_o  out  1  one-cycle strobe on each write to OUT_REG
- pc_o  out  ADDR_W  current PC
- retired_o  out  CNT_W  retired-instruction count
- halted_o  out  1  core in HALT

## Operation
- Instruction fields: [31] B jump, [30] C conditional branch, [29] HALT, [28:27] WS, [26:23] ALUop, [22:18] RA1, [17:13] RA2, [12:8] WA, [7:0] imm.
- ALUop: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 LT, 9 LTU, 10 EQ, 11 NE, 12 GE, 13 GEU, 14–15 result 0. Shifts use low log2(DATA_W) bits of RD2. Compare ops: result = flag zero-extended; flag = 0 for non-compare ops. Arithmetic wraps mod 2^DATA_W.
- WS: 00 sext(imm), 01 sext(in_data_i), 10 ALU result, 11 zero.
- Next PC, priority order: HALT → PC unchanged, enter HALT; B → PC + (sext(imm)<<2); C & flag → PC + (sext(imm)<<2); else PC+4. PC wraps mod 2^ADDR_W.
- Write-back when B=0, C=0, HALT=0. Writes to register 0 discarded; register 0 reads 0. Write to OUT_REG also loads out_data_o, pulses out_valid_o.
- FSM: FETCH → (imem_ack_i) latch instr, EXEC → commit, FETCH; EXEC with HALT=1 → HALT (absorbing until reset).
- EXEC with WS=01 and write-back enabled: in_ready_o=1; stall in EXEC until in_valid_i; commit on the handshake cycle. No handshake for branch/HALT instructions even if WS=01.
- retired_o increments on every commit, including branches and HALT; wraps.

## Timing
- Reset values: state FETCH, PC=RESET_PC, all registers 0, out_data_o 0, out_valid_o 0, retired_o 0, halted_o 0, in_ready_o 0.
- imem_req_o high throughout FETCH, low otherwise; imem_addr_o stable while requesting. imem_ack_i outside FETCH ignored.
- Zero-wait memory (ack in request cycle): 2 cycles/instruction; each wait cycle adds 1.
- Reset mid-fetch: request deasserted in the cycle after reset is sampled; the first post-reset fetch is at RESET_PC.
- Reads in EXEC see pre-commit values (RA = WA reads old value).
- out_valid_o, pc_o, retired_o update the cycle after the commit edge.

## Structure
- Package mc_core_pkg: ALUop and WS constants, FSM state enum, instruction field bit positions.
- Sub-module mc_regfile (NREG × DATA_W, 2 async read ports, 1 sync write port, x0 = 0, sync active-low reset clears all). ALU and FSM live in the core.

## Test plan
- Reset, zero-wait memory: imm=0xFF, WS=00, WA=1 → x1=0xFFFFFFFF, retired=1, PC=4 after 2 cycles.
- x1=5, x2=3, SUB, WS=10, WA=31 → out_data_o=2, one-cycle out_valid_o; WA=0 → x0 stays 0, no strobe.
- C=1, LT, x1=-1, x2=1, imm=0xFE → PC 0x10→0x08; same with x1=2 → PC 0x14, no write-back.
- WS=01, in_valid_i low 3 cycles, then in_data_i=0x200 (IN_W=10) → 3 stall cycles, in_ready_o high, reg = 0xFFFFFE00.
- Ack delayed 4 cycles, rst_i low in cycle 2 → request dropped; next fetch at RESET_PC; late ack ignored.
- HALT at PC 0x0C → halted_o=1, PC=0x0C, no further requests; retired unchanged until reset.
